// File: rtl/sparse_act_decoder.sv
// -----------------------------------------------------------------------------
// sparse_act_decoder
//   Expands a compressed activation vector (N-bit occupancy bitmap plus a
//   packed stream of nonzero values in ascending index order) into a dense
//   stream of N signed values, index 0 first and index N-1 last.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start          one-cycle pulse, accepted only while idle; latches bitmap_in
//   bitmap_in      occupancy bitmap, bit i set = element i is nonzero
//   busy           high from the cycle after an accepted start through the
//                  final output transfer
//   done           one-cycle pulse after the final output transfer
//   nnz_count      popcount of the latched bitmap
//   elem_valid/elem_data/elem_ready   packed nonzero element handshake
//   out_valid/out_data/out_index/out_last/out_ready   dense output handshake
//   err_zero_elem  sticky flag: a packed element equal to zero was accepted
//
// Optional build macro
//   SPARSE_DEC_CHECK_EN  builds the zero-element check; when undefined the
//                        err_zero_elem output is tied low.
// -----------------------------------------------------------------------------
module sparse_act_decoder #(
  parameter int N  = 128,
  parameter int DW = 9,
  parameter int IW = 7,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N-1:0]         bitmap_in,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        nnz_count,
  input  logic                 elem_valid,
  input  logic signed [DW-1:0] elem_data,
  output logic                 elem_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic [IW-1:0]        out_index,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 err_zero_elem
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [IW-1:0] LAST_POS = IW'(N - 1);
  localparam logic [IW-1:0] POS_ONE  = IW'(1);

  // Number of set bits in an occupancy bitmap.
  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [1:0]           state_r;
  logic [N-1:0]         bitmap_r;
  logic [IW-1:0]        pos_r;
  logic                 busy_r;
  logic                 done_r;
  logic [CW-1:0]        nnz_r;
  logic                 out_valid_r;
  logic signed [DW-1:0] out_data_r;
  logic [IW-1:0]        out_index_r;
  logic                 out_last_r;

  logic                 cur_bit_s;
  logic                 load_ok_s;
  logic                 load_s;
  logic                 elem_ready_s;
  logic                 start_ok_s;
  logic                 out_xfer_s;

  // Load decision for the dense output register at the current position.
  always_comb begin
    cur_bit_s  = bitmap_r[pos_r];
    load_ok_s  = !out_valid_r || out_ready;
    start_ok_s = (state_r == ST_IDLE) && start;
    out_xfer_s = out_valid_r && out_ready;
    if (state_r == ST_RUN) begin
      // Occupied positions wait for a packed element; empty ones insert a zero.
      elem_ready_s = cur_bit_s && load_ok_s;
      load_s       = load_ok_s && (!cur_bit_s || elem_valid);
    end else begin
      elem_ready_s = 1'b0;
      load_s       = 1'b0;
    end
  end

  // Control FSM: state, position counter, latched bitmap, busy/done, count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      bitmap_r <= {N{1'b0}};
      pos_r    <= {IW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      nnz_r    <= {CW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            bitmap_r <= bitmap_in;
            pos_r    <= {IW{1'b0}};
            nnz_r    <= popcount(bitmap_in);
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_s) begin
            pos_r <= pos_r + POS_ONE;
            if (pos_r == LAST_POS) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (out_xfer_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Dense output register: loads on a permitted load, drains on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_index_r <= {IW{1'b0}};
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= cur_bit_s ? elem_data : {DW{1'b0}};
      out_index_r <= pos_r;
      out_last_r  <= (pos_r == LAST_POS);
    end else if (out_xfer_s) begin
      // Data and index are left as-is; only the qualifiers drop.
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

`ifdef SPARSE_DEC_CHECK_EN
  logic err_r;

  // Sticky zero-element flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if (elem_valid && elem_ready_s && (elem_data == {DW{1'b0}})) begin
      err_r <= 1'b1;
    end
  end

  assign err_zero_elem = err_r;
`else
  assign err_zero_elem = 1'b0;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign nnz_count  = nnz_r;
  assign elem_ready = elem_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_index  = out_index_r;
  assign out_last   = out_last_r;

endmodule

// File: tb/tb_sparse_act_decoder.sv
// -----------------------------------------------------------------------------
// tb_sparse_act_decoder
//   Table of vectors (bitmap, stimulus modes, expected nonzero count) applied in
//   a loop; each vector's dense stream is checked against a reference built
//   directly from the bitmap and packed values. Hand-written sequences cover
//   start during RUN, reset mid-vector and the zero-element flag.
// -----------------------------------------------------------------------------
module tb_sparse_act_decoder;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [127:0]      bitmap_in;
  logic              busy;
  logic              done;
  logic [7:0]        nnz_count;
  logic              elem_valid;
  logic signed [8:0] elem_data;
  logic              elem_ready;
  logic              out_valid;
  logic signed [8:0] out_data;
  logic [6:0]        out_index;
  logic              out_last;
  logic              out_ready;
  logic              err_zero_elem;

  int checks = 0;
  int errors = 0;

  sparse_act_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bitmap_in     (bitmap_in),
    .busy          (busy),
    .done          (done),
    .nnz_count     (nnz_count),
    .elem_valid    (elem_valid),
    .elem_data     (elem_data),
    .elem_ready    (elem_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .err_zero_elem (err_zero_elem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bitmap;
    int           ev_mode;   // 0 always valid, 1 every other cycle, 2 random
    int           or_mode;   // 0 always ready, 1 random, 2 one 10-cycle stall
    bit           mid_start; // pulse start again during RUN
    int           fixed_id;  // 0 random data, 1 {7,-3,255}, 2 {5,0,6}
    int           exp_nnz;
  } vec_t;

  vec_t tbl [7];

  logic signed [8:0] pk [$];
  logic signed [8:0] dense [128];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [8:0] rnd_nz();
    logic [8:0] r;
    r = 9'($urandom_range(1, 511));
    return $signed(r);
  endfunction

  // Packed stream: fixed prefix or random nonzero values, plus two surplus.
  task automatic make_packed(input int nnz, input int fixed_id);
    pk.delete();
    if (fixed_id == 1) begin
      pk.push_back(9'sd7); pk.push_back(-9'sd3); pk.push_back(9'sd255);
    end else if (fixed_id == 2) begin
      pk.push_back(9'sd5); pk.push_back(9'sd0); pk.push_back(9'sd6);
    end else begin
      for (int i = 0; i < nnz; i++) pk.push_back(rnd_nz());
    end
    pk.push_back(rnd_nz());
    pk.push_back(rnd_nz());
  endtask

  // Reference dense vector: the k-th set bit takes the k-th packed value.
  task automatic build_model(input logic [127:0] bm);
    int k;
    k = 0;
    for (int i = 0; i < 128; i++) begin
      if (bm[i]) begin
        dense[i] = pk[k];
        k++;
      end else begin
        dense[i] = 9'sd0;
      end
    end
  endtask

  task automatic run_vector(input logic [127:0] bm, input int ev_mode, input int or_mode,
                            input bit mid_start, input int exp_nnz);
    int ptr, nout, cyc, done_cnt, first, last, stall_left;
    bit stalled_once, prev_stall, prev_efire, ev, err_model;
    logic signed [8:0] prev_data;
    logic [6:0] prev_index;
    logic prev_last;
    ptr = 0; nout = 0; cyc = 0; done_cnt = 0; first = -1; last = -1;
    stall_left = 0; stalled_once = 0; prev_stall = 0; prev_efire = 0; err_model = 0;
    prev_data = 9'sd0; prev_index = 7'd0; prev_last = 1'b0;
    build_model(bm);

    @(negedge clk);
    start = 1'b1; bitmap_in = bm; elem_valid = 1'b0; out_ready = 1'b1;

    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start && nout == 20) begin
        start = 1'b1;
        bitmap_in = ~bm;
      end
      case (ev_mode)
        0:       ev = 1'b1;
        1:       ev = cyc[0];
        default: ev = ($urandom_range(0, 1) == 1);
      endcase
      elem_valid = ev && (ptr < pk.size());
      elem_data  = (ptr < pk.size()) ? pk[ptr] : 9'sd0;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (nout == 50 && !stalled_once) begin
            stall_left = 10;
            stalled_once = 1'b1;
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      #1;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_index", out_index, prev_index);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) chk("stall_elem_ready", elem_ready, 0);
      if (prev_efire) chk("accept_latency", out_valid, 1);
      chk("no_surplus_ready", (elem_ready && ptr >= exp_nnz), 0);
      chk("busy", busy, (nout < 128));
`ifdef SPARSE_DEC_CHECK_EN
      chk("err_zero_elem", err_zero_elem, err_model);
`else
      chk("err_tied_low", err_zero_elem, 0);
`endif
      if (done) begin
        done_cnt++;
        chk("done_all_out", nout, 128);
        chk("done_timing", cyc, last + 1);
      end
      if (out_valid && out_ready) begin
        chk("out_index", out_index, nout);
        chk("out_data", out_data, dense[nout]);
        chk("out_last", out_last, (nout == 127));
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      prev_efire = elem_valid && elem_ready;
      if (prev_efire) begin
        if (elem_data == 9'sd0) err_model = 1'b1;
        ptr++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_index = out_index;
      prev_last  = out_last;
      cyc++;
    end
    start = 1'b0;
    elem_valid = 1'b0;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL vector_timeout: got %0d outputs expected 128", nout);
    end
    chk("elems_consumed", ptr, exp_nnz);
    chk("nnz_count", nnz_count, exp_nnz);
    if (ev_mode == 0 && or_mode == 0) chk("throughput_span", last - first, 127);
    @(negedge clk);
    #1;
    chk("done_one_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
`ifdef SPARSE_DEC_CHECK_EN
    chk("err_sticky", err_zero_elem, err_model);
`endif
  endtask

  initial begin
    int found;
    logic [127:0] rbm;

    tbl[0] = '{128'h0, 0, 0, 1'b0, 0, 0};
    tbl[1] = '{128'h80000000000000000000000000000022, 0, 0, 1'b0, 1, 3};
    tbl[2] = '{{128{1'b1}}, 1, 0, 1'b0, 0, 128};
    tbl[3] = '{128'h55555555555555555555555555555555, 0, 2, 1'b0, 0, 64};
    tbl[4] = '{{128{1'b1}}, 0, 0, 1'b1, 0, 128};
    tbl[5] = '{128'h20C, 2, 1, 1'b0, 2, 3};
    tbl[6] = '{128'h0000000000000000FFFF0000000000F0, 2, 1, 1'b0, 0, 20};

    rst_n = 1'b0; start = 1'b0; bitmap_in = 128'h0;
    elem_valid = 1'b0; elem_data = 9'sd0; out_ready = 1'b1;
    #1;
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_out_ctrl", {out_valid, out_last, elem_ready}, 0);
    chk("rst_out_data", {out_data, out_index}, 0);
    chk("rst_nnz_err", {nnz_count, err_zero_elem}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      make_packed(tbl[t].exp_nnz, tbl[t].fixed_id);
      run_vector(tbl[t].bitmap, tbl[t].ev_mode, tbl[t].or_mode,
                 tbl[t].mid_start, tbl[t].exp_nnz);
    end

    for (int r = 0; r < 4; r++) begin
      rbm = {$urandom, $urandom, $urandom, $urandom};
      make_packed($countones(rbm), 0);
      run_vector(rbm, 2, 1, 1'b0, $countones(rbm));
    end

    // Reset while the dense output is at index 40.
    make_packed(128, 0);
    @(negedge clk);
    start = 1'b1; bitmap_in = {128{1'b1}}; elem_valid = 1'b1; elem_data = pk[0];
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_index == 7'd40) found = 1;
    end
    if (found == 0) begin
      errors++;
      $display("FAIL reach_index40: got 0 expected 1");
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {busy, done}, 0);
    chk("midrst_out_ctrl", {out_valid, out_last, elem_ready}, 0);
    chk("midrst_out_data", {out_data, out_index}, 0);
    chk("midrst_nnz", nnz_count, 0);
    elem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("postrst_quiet", {out_valid, busy, elem_ready}, 0);
    end

    make_packed(tbl[1].exp_nnz, tbl[1].fixed_id);
    run_vector(tbl[1].bitmap, 0, 0, 1'b0, tbl[1].exp_nnz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
